memc_lane_dma_port: RTL and testbench

Memory-controller-side responder for one execution lane's DMA-to-memory interface. It is the counterpart of the per-lane `dma_cont` initiator. It accepts write and read requests on the `dma__memc__*` / `memc__dma__*` handshake and arbitrates them onto a single-port lane SRAM. Read data returns in order through a credit-limited queue that honours `dma__memc__read_pause`. One instance sits in the PE memory controller for each `stOp_lane`.

---
 rtl/memc_lane_dma_port_if.sv | 31 +++
 rtl/memc_lane_dma_port.sv | 142 ++++++++++++++
 tb/tb_memc_lane_dma_port.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memc_lane_dma_port_if.sv
// DMA-to-memory-controller handshake bundle for one execution lane.
// master: the per-lane DMA initiator; slave: the memory-controller responder.
interface memc_lane_dma_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20
);
    logic                  dma__memc__write_valid;
    logic [ADDR_WIDTH-1:0] dma__memc__write_address;
    logic [DATA_WIDTH-1:0] dma__memc__write_data;
    logic                  memc__dma__write_ready;
    logic                  dma__memc__read_valid;
    logic [ADDR_WIDTH-1:0] dma__memc__read_address;
    logic                  memc__dma__read_ready;
    logic                  dma__memc__read_pause;
    logic [DATA_WIDTH-1:0] memc__dma__read_data;
    logic                  memc__dma__read_data_valid;

    modport master (
        output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
        output dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
        input  memc__dma__write_ready, memc__dma__read_ready,
        input  memc__dma__read_data, memc__dma__read_data_valid
    );

    modport slave (
        input  dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
        input  dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
        output memc__dma__write_ready, memc__dma__read_ready,
        output memc__dma__read_data, memc__dma__read_data_valid
    );
endinterface

// File: rtl/memc_lane_dma_port.sv
// Memory-controller responder for one lane's DMA port: arbitrates DMA writes
// and reads onto a single-port lane SRAM and returns read data in order
// through a credit-limited queue that honours read_pause.
// Optional: define MEMC_LANE_DMA_PORT_STATS_EN to add saturating 16-bit
// write/read accept counters.
module memc_lane_dma_port #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 20,
    parameter int MEM_LATENCY = 2,
    parameter int RDQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    memc_lane_dma_port_if.slave   dma,
    output logic                  memc__sram__enable,
    output logic                  memc__sram__write,
    output logic [ADDR_WIDTH-1:0] memc__sram__address,
    output logic [DATA_WIDTH-1:0] memc__sram__write_data,
    input  logic [DATA_WIDTH-1:0] sram__memc__read_data
`ifdef MEMC_LANE_DMA_PORT_STATS_EN
    ,
    output logic [15:0]           memc__stats__write_count,
    output logic [15:0]           memc__stats__read_count
`endif
);
    localparam int QAW = $clog2(RDQ_DEPTH);
    localparam int CW  = $clog2(RDQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RDQ_DEPTH);

    typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_t;

    logic                  init_p0;     // first cycle after reset falls
    logic                  blank;       // force every output to zero
    logic                  wr_acc, rd_acc, pop, push, rd_credit, rdq_empty;
    grant_t                last_grant;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         rdq_count;
    logic [QAW-1:0]        rdq_wr_ptr, rdq_rd_ptr;
    logic [DATA_WIDTH-1:0] rdq_mem [RDQ_DEPTH];
    logic [MEM_LATENCY:0]  rd_vld_p;    // bit 0 aligns with SRAM command, top bit with SRAM data
    logic                  sram_en_p1, sram_wr_p1;
    logic [ADDR_WIDTH-1:0] sram_addr_p1;
    logic [DATA_WIDTH-1:0] sram_wdata_p1;

    assign blank     = reset_poweron | init_p0;
    assign rdq_empty = (rdq_count == '0);
    assign pop       = !rdq_empty && !dma.dma__memc__read_pause && !blank;
    assign push      = rd_vld_p[MEM_LATENCY];
    // A pop in the same cycle frees a slot, so back-to-back reads never bubble.
    assign rd_credit = (outstanding < DEPTH_C) || pop;

    // Arbitrate: alternate under contention, writes win when reads lack credit.
    always_comb begin
        wr_acc = 1'b0;
        rd_acc = 1'b0;
        if (!blank) begin
            if (dma.dma__memc__write_valid && dma.dma__memc__read_valid) begin
                if (rd_credit && last_grant == GRANT_WR) rd_acc = 1'b1;
                else                                     wr_acc = 1'b1;
            end else if (dma.dma__memc__write_valid) begin
                wr_acc = 1'b1;
            end else if (dma.dma__memc__read_valid) begin
                rd_acc = rd_credit;
            end
        end
    end

    assign dma.memc__dma__write_ready     = wr_acc;
    assign dma.memc__dma__read_ready      = rd_acc;
    assign dma.memc__dma__read_data_valid = pop;
    assign dma.memc__dma__read_data       = blank ? '0 : rdq_mem[rdq_rd_ptr];

    // Gating with reset drops a command registered just before reset asserts.
    assign memc__sram__enable     = sram_en_p1 & !blank;
    assign memc__sram__write      = sram_wr_p1 & !blank;
    assign memc__sram__address    = blank ? '0 : sram_addr_p1;
    assign memc__sram__write_data = blank ? '0 : sram_wdata_p1;

    // Control state: credits, grant history, read tags, queue pointers.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            init_p0     <= 1'b1;
            outstanding <= '0;
            last_grant  <= GRANT_RD;
            rd_vld_p    <= '0;
            sram_en_p1  <= 1'b0;
            sram_wr_p1  <= 1'b0;
            rdq_count   <= '0;
            rdq_wr_ptr  <= '0;
            rdq_rd_ptr  <= '0;
        end else begin
            init_p0 <= 1'b0;
            case ({rd_acc, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (wr_acc)      last_grant <= GRANT_WR;
            else if (rd_acc) last_grant <= GRANT_RD;
            // Stage boundary: accept -> SRAM command -> SRAM data return.
            rd_vld_p   <= {rd_vld_p[MEM_LATENCY-1:0], rd_acc};
            sram_en_p1 <= wr_acc | rd_acc;
            sram_wr_p1 <= wr_acc;
            if (push) rdq_wr_ptr <= rdq_wr_ptr + QAW'(1);
            if (pop)  rdq_rd_ptr <= rdq_rd_ptr + QAW'(1);
            case ({push, pop})
                2'b10:   rdq_count <= rdq_count + CW'(1);
                2'b01:   rdq_count <= rdq_count - CW'(1);
                default: rdq_count <= rdq_count;
            endcase
        end
    end

    // Datapath registers: SRAM command payload and queue storage.
    always_ff @(posedge clk) begin
        if (wr_acc)
            sram_addr_p1 <= dma.dma__memc__write_address;
        else if (rd_acc)
            sram_addr_p1 <= dma.dma__memc__read_address;
        if (wr_acc)
            sram_wdata_p1 <= dma.dma__memc__write_data;
        if (push)
            rdq_mem[rdq_wr_ptr] <= sram__memc__read_data;
    end

`ifdef MEMC_LANE_DMA_PORT_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating accept counters.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            memc__stats__write_count <= '0;
            memc__stats__read_count  <= '0;
        end else begin
            if (wr_acc) memc__stats__write_count <= sat_inc16(memc__stats__write_count);
            if (rd_acc) memc__stats__read_count  <= sat_inc16(memc__stats__read_count);
        end
    end
`endif
endmodule

// File: tb/tb_memc_lane_dma_port.sv
// Bench for memc_lane_dma_port: directed vectors, a behavioural SRAM, and a
// queue-based scoreboard checked every cycle.
module tb_memc_lane_dma_port;
    localparam int DW = 32, AW = 20, LAT = 2, DEPTH = 4, RET = LAT + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sram_en, sram_wr;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
`ifdef MEMC_LANE_DMA_PORT_STATS_EN
    logic [15:0]   st_wr, st_rd;
`endif

    memc_lane_dma_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    memc_lane_dma_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .RDQ_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset_poweron          (rst),
        .dma                    (bus),
        .memc__sram__enable     (sram_en),
        .memc__sram__write      (sram_wr),
        .memc__sram__address    (sram_addr),
        .memc__sram__write_data (sram_wdata),
        .sram__memc__read_data  (sram_rdata)
`ifdef MEMC_LANE_DMA_PORT_STATS_EN
        ,
        .memc__stats__write_count (st_wr),
        .memc__stats__read_count  (st_rd)
`endif
    );

    int n_vec = 0, n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return 32'hC0D0_0000 | {22'd0, a};
    endfunction

    // Behavioural SRAM with a two-cycle read latency.
    logic [31:0]   smem [1024];
    logic [1023:0] swr = '0;
    logic [31:0]   sp0, sp1;
    always @(posedge clk) begin
        if (sram_en && sram_wr) begin
            smem[sram_addr[9:0]] <= sram_wdata;
            swr[sram_addr[9:0]]  <= 1'b1;
        end
        sp0 <= (sram_en && !sram_wr) ?
               (swr[sram_addr[9:0]] ? smem[sram_addr[9:0]] : init_val(sram_addr[9:0])) : 32'hA5A5A5A5;
        sp1 <= sp0;
    end
    assign sram_rdata = sp1;

    // Scoreboard: pending reads with due cycle, serialized memory image.
    typedef struct {int due; logic [31:0] data;} rd_t;
    rd_t         q[$];
    logic [31:0] mm [1024];

    initial begin : model
        logic          last_rd, init_m, blk, pop, credit, ew, er;
        logic          pc_en, pc_wr;
        logic [AW-1:0] pc_a;
        logic [DW-1:0] pc_d;
        int            cyc;
        for (int i = 0; i < 1024; i++) mm[i] = init_val(10'(i));
        last_rd = 1'b1; init_m = 1'b0; cyc = 0;
        pc_en = 1'b0; pc_wr = 1'b0; pc_a = '0; pc_d = '0;
        forever begin
            @(negedge clk);
            #2;
            blk = rst || init_m;
            if (!blk && pc_en && pc_wr) mm[pc_a[9:0]] = pc_d;
            pop = !blk && q.size() > 0 && q[0].due <= cyc && !bus.dma__memc__read_pause;
            chk("rd_valid", bus.memc__dma__read_data_valid, pop);
            if (pop)      chk("rd_data", bus.memc__dma__read_data, q[0].data);
            else if (blk) chk("rd_data_blank", bus.memc__dma__read_data, 0);
            if (blk) begin
                chk("sram_en_blank", sram_en, 0);
                chk("sram_wr_blank", sram_wr, 0);
                chk("sram_addr_blank", sram_addr, 0);
                chk("sram_wdata_blank", sram_wdata, 0);
            end else begin
                chk("sram_en", sram_en, pc_en);
                if (pc_en) begin
                    chk("sram_wr", sram_wr, pc_wr);
                    chk("sram_addr", sram_addr, pc_a);
                    if (pc_wr) chk("sram_wdata", sram_wdata, pc_d);
                end
            end
            credit = (q.size() < DEPTH) || pop;
            ew = 1'b0; er = 1'b0;
            if (!blk) begin
                if (bus.dma__memc__write_valid && bus.dma__memc__read_valid) begin
                    if (credit && !last_rd) er = 1'b1;
                    else                    ew = 1'b1;
                end else if (bus.dma__memc__write_valid) ew = 1'b1;
                else if (bus.dma__memc__read_valid)      er = credit;
            end
            chk("write_ready", bus.memc__dma__write_ready, ew);
            chk("read_ready", bus.memc__dma__read_ready, er);
            if (pop) void'(q.pop_front());
            pc_en = ew || er;
            pc_wr = ew;
            pc_a  = ew ? bus.dma__memc__write_address : bus.dma__memc__read_address;
            pc_d  = bus.dma__memc__write_data;
            if (ew) last_rd = 1'b0;
            if (er) begin
                q.push_back('{due: cyc + RET, data: mm[bus.dma__memc__read_address[9:0]]});
                last_rd = 1'b1;
            end
            if (rst) begin
                q.delete();
                last_rd = 1'b1;
                pc_en = 1'b0;
            end
            init_m = rst;
            cyc++;
        end
    end

    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] ra, input logic p, input logic r);
        @(negedge clk);
        bus.dma__memc__write_valid   = wv;
        bus.dma__memc__write_address = wa;
        bus.dma__memc__write_data    = wd;
        bus.dma__memc__read_valid    = rv;
        bus.dma__memc__read_address  = ra;
        bus.dma__memc__read_pause    = p;
        rst = r;
        #3;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int wi, ri, n3;
        logic [31:0] e4;
        rst = 1'b1;
        bus.dma__memc__write_valid = 1'b0; bus.dma__memc__write_address = '0;
        bus.dma__memc__write_data = '0; bus.dma__memc__read_valid = 1'b0;
        bus.dma__memc__read_address = '0; bus.dma__memc__read_pause = 1'b0;

        // Reset with both valids up: nothing accepted, even in the first cycle after.
        drive(1'b1, 20'h5, 32'h1, 1'b1, 20'h6, 1'b0, 1'b1);
        chk("rst_wr_ready", bus.memc__dma__write_ready, 0);
        chk("rst_rd_ready", bus.memc__dma__read_ready, 0);
        drive(1'b1, 20'h5, 32'h1, 1'b1, 20'h6, 1'b0, 1'b0);
        chk("init_wr_ready", bus.memc__dma__write_ready, 0);
        chk("init_rd_ready", bus.memc__dma__read_ready, 0);
        chk("init_sram_en", sram_en, 0);
        idle();

        // Write then read back with default latency.
        drive(1'b1, 20'h00010, 32'hDEADBEEF, 1'b0, '0, 1'b0, 1'b0);
        chk("t1_wr_ready", bus.memc__dma__write_ready, 1);
        idle();
        chk("t1_sram_en", sram_en, 1);
        chk("t1_sram_wr", sram_wr, 1);
        chk("t1_sram_addr", sram_addr, 20'h00010);
        chk("t1_sram_wdata", sram_wdata, 32'hDEADBEEF);
        drive(1'b0, '0, '0, 1'b1, 20'h00010, 1'b0, 1'b0);
        chk("t1_rd_ready", bus.memc__dma__read_ready, 1);
        idle();
        chk("t1_rd_sram_en", sram_en, 1);
        chk("t1_rd_sram_wr", sram_wr, 0);
        chk("t1_early_valid", bus.memc__dma__read_data_valid, 0);
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("t1_early_valid", bus.memc__dma__read_data_valid, 0);
        end
        idle();
        chk("t1_valid", bus.memc__dma__read_data_valid, 1);
        chk("t1_data", bus.memc__dma__read_data, 32'hDEADBEEF);
        idle();
        chk("t1_valid_after", bus.memc__dma__read_data_valid, 0);

        // Contention right after reset: W, R, W, R ...
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        wi = 0; ri = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, AW'(20'h100 + wi), 32'h1000_0000 + 32'(wi), 1'b1, AW'(20'h200 + ri), 1'b0, 1'b0);
            chk("t2_w_grant", bus.memc__dma__write_ready, (k % 2) == 0);
            chk("t2_r_grant", bus.memc__dma__read_ready, (k % 2) == 1);
            if (bus.memc__dma__write_ready) wi++;
            if (bus.memc__dma__read_ready)  ri++;
        end
        repeat (8) idle();

        // Paused reads: credit limit stops acceptance at four.
        n3 = 0;
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(20'h100 + n3), 1'b1, 1'b0);
            chk("t3_rd_ready", bus.memc__dma__read_ready, k < 4);
            chk("t3_paused_valid", bus.memc__dma__read_data_valid, 0);
            if (bus.memc__dma__read_ready) n3++;
        end
        drive(1'b0, '0, '0, 1'b1, 20'h104, 1'b0, 1'b0);
        chk("t3_ready_on_pop", bus.memc__dma__read_ready, 1);
        chk("t3_pop0_valid", bus.memc__dma__read_data_valid, 1);
        chk("t3_pop0_data", bus.memc__dma__read_data, 32'h1000_0000);
        for (int j = 1; j < 4; j++) begin
            idle();
            chk("t3_pop_valid", bus.memc__dma__read_data_valid, 1);
            chk("t3_pop_data", bus.memc__dma__read_data, 32'h1000_0000 + 32'(j));
        end
        idle();
        chk("t3_tail_valid", bus.memc__dma__read_data_valid, 1);
        chk("t3_tail_data", bus.memc__dma__read_data, init_val(10'h104));
        repeat (4) idle();

        // Eight back-to-back reads stream out contiguously.
        for (int k = 0; k < 13; k++) begin
            if (k < 8) drive(1'b0, '0, '0, 1'b1, AW'(20'h100 + k), 1'b0, 1'b0);
            else       idle();
            if (k < 8) chk("t4_rd_ready", bus.memc__dma__read_ready, 1);
            chk("t4_valid", bus.memc__dma__read_data_valid, (k >= 4) && (k < 12));
            if (k >= 4 && k < 12) begin
                e4 = (k < 8) ? 32'h1000_0000 + 32'(k - 4) : init_val(10'(32'h100 + k - 4));
                chk("t4_data", bus.memc__dma__read_data, e4);
            end
        end

        // Reset with reads in flight and a read command pending.
        drive(1'b1, 20'h20, 32'h55, 1'b0, '0, 1'b0, 1'b0);
        chk("t5_wr_ready", bus.memc__dma__write_ready, 1);
        drive(1'b0, '0, '0, 1'b1, 20'h20, 1'b0, 1'b0);
        chk("t5_rd_ready0", bus.memc__dma__read_ready, 1);
        drive(1'b0, '0, '0, 1'b1, 20'h11, 1'b0, 1'b0);
        chk("t5_rd_ready1", bus.memc__dma__read_ready, 1);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("t5_cmd_dropped", sram_en, 0);
        for (int k = 0; k < 7; k++) begin
            idle();
            chk("t5_no_valid", bus.memc__dma__read_data_valid, 0);
        end
        chk("t5_outstanding", dut.outstanding, 0);
        drive(1'b0, '0, '0, 1'b1, 20'h20, 1'b0, 1'b0);
        chk("t5_ready_after", bus.memc__dma__read_ready, 1);
        repeat (3) idle();
        idle();
        chk("t5_valid", bus.memc__dma__read_data_valid, 1);
        chk("t5_data", bus.memc__dma__read_data, 32'h55);
        repeat (2) idle();

`ifdef MEMC_LANE_DMA_PORT_STATS_EN
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        chk("st_clear", st_wr, 0);
        for (int k = 0; k < 3; k++) drive(1'b1, 20'h300, 32'(k), 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, '0, '0, 1'b1, 20'h300, 1'b0, 1'b0);
        repeat (8) idle();
        chk("st_wr_3", st_wr, 3);
        chk("st_rd_5", st_rd, 5);
        for (int k = 0; k < 65531; k++) drive(1'b1, 20'h300, 32'(k), 1'b0, '0, 1'b0, 1'b0);
        idle();
        chk("st_wr_fffe", st_wr, 16'hFFFE);
        for (int k = 0; k < 3; k++) drive(1'b1, 20'h300, 32'(k), 1'b0, '0, 1'b0, 1'b0);
        idle();
        chk("st_wr_sat", st_wr, 16'hFFFF);
        chk("st_rd_hold", st_rd, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
